// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory access stage.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } mem_state_t;

   localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

   // Wide enough for any TIMEOUT in 1..255.
   localparam int TIMER_W = 8;

   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/mem_access_unit_wait_timer.sv
// Wait-cycle counter for an outstanding memory request; tc_o flags the last allowed cycle.
module wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic inc_i,
   output logic tc_o
);
   import cpu_pkg::*;

   localparam logic [TIMER_W-1:0] TC_VAL = TIMER_W'(TIMEOUT - 1);

   logic [TIMER_W-1:0] cnt_q;
   logic [TIMER_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + TIMER_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: MAR/MDR plus a req/ack handshake FSM with bounded wait.
// Every output comes straight from a flop; next values are computed one cycle ahead.
module mem_access_unit #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             marEn,
   input  logic [WIDTH-1:0] addrIn,
   input  logic             mdrEn,
   input  logic [WIDTH-1:0] dataIn,
   input  logic             rd,
   input  logic             wr,
   output logic [WIDTH-1:0] mdrOut,
   output logic             memDone,
   output logic             memErr,
   output logic             busy,
   output logic [WIDTH-1:0] memAddr,
   output logic [WIDTH-1:0] memWdata,
   input  logic [WIDTH-1:0] memRdata,
   output logic             memReq,
   output logic             memWe,
   input  logic             memAck
);
   import cpu_pkg::*;

   mem_state_t       state_q, state_d;
   logic [WIDTH-1:0] mar_q, mar_d;
   logic [WIDTH-1:0] mdr_q, mdr_d;
   logic             we_q, we_d;
   logic             req_q, req_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             tmr_clear;
   logic             tmr_inc;
   logic             tmr_tc;

   wait_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_wait_timer (
      .clk    (clk),
      .reset  (reset),
      .clear_i(tmr_clear),
      .inc_i  (tmr_inc),
      .tc_o   (tmr_tc)
   );

   always_comb begin
      state_d   = state_q;
      mar_d     = mar_q;
      mdr_d     = mdr_q;
      we_d      = we_q;
      tmr_clear = 1'b0;
      tmr_inc   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (marEn) begin
               mar_d = addrIn;
            end
            if (mdrEn) begin
               mdr_d = dataIn;
            end
            // The start decision looks at the MAR already held, not at addrIn.
            if (rd && wr) begin
               state_d = ERR;
            end else if (rd || wr) begin
               if (is_word_aligned(mar_q[1:0])) begin
                  state_d   = REQ;
                  we_d      = wr;
                  tmr_clear = 1'b1;
               end else begin
                  state_d = ERR;
               end
            end
         end
         REQ: begin
            // An ack on the final allowed wait cycle still completes the access.
            if (memAck) begin
               state_d = DONE;
               if (!we_q) begin
                  mdr_d = memRdata;
               end
            end else if (tmr_tc) begin
               state_d = ERR;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      req_d  = (state_d == REQ);
      done_d = (state_d == DONE);
      err_d  = (state_d == ERR);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mar_q   <= '0;
         mdr_q   <= '0;
         we_q    <= 1'b0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         we_q    <= we_d;
         req_q   <= req_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign mdrOut   = mdr_q;
   assign memAddr  = mar_q;
   assign memWdata = mdr_q;
   assign memReq   = req_q;
   assign memWe    = we_q;
   assign memDone  = done_q;
   assign memErr   = err_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expectations, a negedge monitor checks them.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        marEn = 1'b0;
   logic [31:0] addrIn = '0;
   logic        mdrEn = 1'b0;
   logic [31:0] dataIn = '0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] mdrOut;
   logic        memDone;
   logic        memErr;
   logic        busy;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic [31:0] memRdata = '0;
   logic        memReq;
   logic        memWe;
   logic        memAck = 1'b0;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        is_err;
      logic [31:0] mdr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      int          reqs;
      int          strobe_cyc;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } chk_t;

   exp_t exp_q[$];
   chk_t dir_q[$];

   mem_access_unit #(
      .WIDTH  (32),
      .TIMEOUT(4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .marEn   (marEn),
      .addrIn  (addrIn),
      .mdrEn   (mdrEn),
      .dataIn  (dataIn),
      .rd      (rd),
      .wr      (wr),
      .mdrOut  (mdrOut),
      .memDone (memDone),
      .memErr  (memErr),
      .busy    (busy),
      .memAddr (memAddr),
      .memWdata(memWdata),
      .memRdata(memRdata),
      .memReq  (memReq),
      .memWe   (memWe),
      .memAck  (memAck)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s: got %h want %h", n, a, x);
      end
   endtask

   // Monitor: the only process that steps checks/errors.
   initial begin
      int   req_cnt;
      exp_t e;
      chk_t c;
      req_cnt = 0;
      forever begin
         @(negedge clk);
         while (dir_q.size() > 0) begin
            c = dir_q.pop_front();
            cmp(c.name, c.act, c.exp);
         end
         if (reset) begin
            req_cnt = 0;
         end else begin
            if (memReq) begin
               req_cnt++;
               if (exp_q.size() > 0) begin
                  e = exp_q[0];
                  cmp("memAddr_during_req", memAddr, e.addr);
                  cmp("memWe_during_req", 32'(memWe), 32'(e.we));
                  cmp("memWdata_during_req", memWdata, e.wdata);
               end
            end
            if (memDone || memErr) begin
               if (exp_q.size() == 0) begin
                  cmp("unexpected_pulse", {30'd0, memDone, memErr}, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  cmp("memErr_pulse", 32'(memErr), 32'(e.is_err));
                  cmp("memDone_pulse", 32'(memDone), 32'(!e.is_err));
                  cmp("mdrOut_at_pulse", mdrOut, e.mdr);
                  cmp("memReq_cycles", 32'(req_cnt), 32'(e.reqs));
                  cmp("pulse_cycle", 32'(cyc), 32'(e.strobe_cyc + 1 + e.reqs));
               end
               req_cnt = 0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic direct(input string n, input logic [31:0] a, input logic [31:0] x);
      chk_t c;
      c.name = n;
      c.act  = a;
      c.exp  = x;
      dir_q.push_back(c);
   endtask

   task automatic load(input logic me, input logic [31:0] a, input logic de, input logic [31:0] d);
      marEn = me; addrIn = a; mdrEn = de; dataIn = d;
      step();
      marEn = 1'b0; mdrEn = 1'b0;
   endtask

   // Issues one strobe, plays memory for 8 cycles (ack in REQ cycle ack_at, 0 = never).
   task automatic access(input logic r, input logic w, input int ack_at, input logic [31:0] rdata,
                         input logic lock, input logic is_err, input logic [31:0] mdr,
                         input logic [31:0] addr, input logic [31:0] wdata, input int reqs);
      exp_t e;
      e.is_err = is_err; e.mdr = mdr; e.addr = addr; e.wdata = wdata;
      e.we = w; e.reqs = reqs; e.strobe_cyc = cyc;
      exp_q.push_back(e);
      rd = r; wr = w;
      step();
      rd = 1'b0; wr = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         memAck   = (k == ack_at);
         memRdata = rdata;
         if (lock && k == 1) begin
            marEn = 1'b1; addrIn = 32'h0000_0FFC;
            mdrEn = 1'b1; dataIn = 32'h5555_5555;
            rd    = 1'b1;
         end
         step();
         marEn = 1'b0; mdrEn = 1'b0; rd = 1'b0; memAck = 1'b0;
      end
   endtask

   initial begin
      step();
      step();
      direct("reset_memReq", 32'(memReq), 32'd0);
      direct("reset_memWe", 32'(memWe), 32'd0);
      direct("reset_memDone", 32'(memDone), 32'd0);
      direct("reset_memErr", 32'(memErr), 32'd0);
      direct("reset_busy", 32'(busy), 32'd0);
      direct("reset_mdrOut", mdrOut, 32'd0);
      direct("reset_memAddr", memAddr, 32'd0);
      direct("reset_memWdata", memWdata, 32'd0);
      reset = 1'b0;
      step();

      // Read, ack in 3rd REQ cycle.
      load(1'b1, 32'h100, 1'b0, 32'h0);
      access(1'b1, 1'b0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h100, 32'h0, 3);

      // Write, ack in 1st REQ cycle; memRdata must not reach MDR.
      load(1'b1, 32'h20, 1'b1, 32'h1234_5678);
      access(1'b0, 1'b1, 1, 32'hAAAA_5555, 1'b0, 1'b0, 32'h1234_5678, 32'h20, 32'h1234_5678, 1);

      // Misaligned read.
      load(1'b1, 32'h102, 1'b0, 32'h0);
      access(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 32'h102, 32'h1234_5678, 0);

      // rd and wr together.
      load(1'b1, 32'h40, 1'b0, 32'h0);
      access(1'b1, 1'b1, 0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 32'h40, 32'h1234_5678, 0);

      // Timeout with no ack, then ack on the last allowed cycle.
      access(1'b1, 1'b0, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h1234_5678, 32'h40, 32'h1234_5678, 4);
      access(1'b1, 1'b0, 4, 32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h40, 32'h1234_5678, 4);

      // Busy lockout: marEn/mdrEn/rd during REQ are ignored.
      load(1'b1, 32'h80, 1'b0, 32'h0);
      access(1'b0, 1'b1, 3, 32'h0, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h80, 32'hCAFE_F00D, 3);
      direct("lockout_mar", memAddr, 32'h80);
      direct("lockout_mdr", mdrOut, 32'hCAFE_F00D);

      // Stray ack while idle.
      memAck = 1'b1; memRdata = 32'h0BAD_F00D;
      step();
      step();
      memAck = 1'b0;
      step();
      direct("stray_ack_mdr", mdrOut, 32'hCAFE_F00D);
      direct("stray_ack_busy", 32'(busy), 32'd0);
      direct("stray_ack_memReq", 32'(memReq), 32'd0);

      // Reset in the middle of a request.
      load(1'b1, 32'h200, 1'b0, 32'h0);
      rd = 1'b1;
      step();
      rd = 1'b0;
      step();
      direct("midreq_memReq_before", 32'(memReq), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      direct("midreset_memReq", 32'(memReq), 32'd0);
      direct("midreset_busy", 32'(busy), 32'd0);
      direct("midreset_mar", memAddr, 32'd0);
      direct("midreset_mdr", mdrOut, 32'd0);

      // Read after reset completes normally from MAR=0.
      access(1'b1, 1'b0, 2, 32'h1357_9BDF, 1'b0, 1'b0, 32'h1357_9BDF, 32'h0, 32'h0, 2);

      direct("pending_expectations", 32'(exp_q.size()), 32'd0);
      step();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
